// File: rtl/i2c_tof_target_responder.sv
`timescale 1ns / 1ps
// I2C target responder with a 16-bit register pointer, auto-increment and an
// open-drain SDA pull output. SCL/SDA are oversampled by clk_i; no clock stretching.
module i2c_tof_target_responder #(
  parameter logic [6:0]  SLAVE_ADDR      = 7'h11,
  parameter int unsigned SDA_HOLD_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_pull_o,
  output logic [15:0] reg_addr_o,
  output logic [7:0]  reg_wdata_o,
  output logic        reg_we_o,
  output logic        reg_re_o,
  input  logic [7:0]  reg_rdata_i,
  output logic        busy_o,
  output logic        xfer_done_o
);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtrH, StPtrHAck, StPtrL, StPtrLAck,
    StWdata, StWdataAck, StTx, StRxAck, StWaitStop
  } state_e;

  // [0],[1] synchronizer, [2] previous-value stage for edge detection
  logic [2:0] scl_q, sda_q;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  sr_q, sr_d;
  logic [7:0]  shadow_q, shadow_d;
  logic [7:0]  tx_q, tx_d;
  logic        rw_q, rw_d;
  logic        ack_on_q, ack_on_d;
  logic        pend_q, pend_d;
  logic [3:0]  hold_q, hold_d;
  logic        pull_q, pull_d;
  logic        we_q, we_d;
  logic        re_q, re_d;
  logic        re_dly_q, re_dly_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [15:0] addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic scl_rise, scl_fall, start_ev, stop_ev;
  logic [7:0] rx_byte;

  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start_ev = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop_ev  = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
  assign rx_byte  = {sr_q[6:0], sda_q[1]};

  // Input synchronizers; reset to the idle-bus level so no event fires on release
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  // Protocol FSM: bit sampling on SCL rise, SDA scheduling on SCL fall
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    shadow_d = shadow_q;
    tx_d     = tx_q;
    rw_d     = rw_q;
    ack_on_d = ack_on_q;
    pend_d   = pend_q;
    hold_d   = hold_q;
    pull_d   = pull_q;
    we_d     = 1'b0;
    re_d     = 1'b0;
    re_dly_d = re_q;
    wdata_d  = wdata_q;
    addr_d   = addr_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    if (re_dly_q) tx_d = reg_rdata_i;

    // Pending SDA level is applied once the hold delay after the SCL fall expires
    if (hold_q != 4'd0) begin
      hold_d = hold_q - 4'd1;
      if (hold_q == 4'd1) pull_d = pend_q;
    end

    if (stop_ev) begin
      state_d  = StIdle;
      pull_d   = 1'b0;
      hold_d   = 4'd0;
      ack_on_d = 1'b0;
      busy_d   = 1'b0;
      done_d   = busy_q;
    end else if (start_ev) begin
      state_d  = StAddr;
      cnt_d    = 3'd0;
      pull_d   = 1'b0;
      hold_d   = 4'd0;
      ack_on_d = 1'b0;
      busy_d   = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        StAddr, StPtrH, StPtrL, StWdata: begin
          sr_d  = rx_byte;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            case (state_q)
              StAddr: begin
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  state_d = StAddrAck;
                  busy_d  = 1'b1;
                  rw_d    = rx_byte[0];
                  re_d    = rx_byte[0];
                end else begin
                  state_d = StWaitStop;
                end
              end
              StPtrH: begin
                shadow_d = rx_byte;
                state_d  = StPtrHAck;
              end
              StPtrL: begin
                addr_d  = {shadow_q, rx_byte};
                state_d = StPtrLAck;
              end
              default: begin
                we_d    = 1'b1;
                wdata_d = rx_byte;
                state_d = StWdataAck;
              end
            endcase
          end
        end
        StTx: begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = StRxAck;
        end
        StRxAck: begin
          if (!sda_q[1]) begin
            addr_d  = addr_q + 16'd1;
            re_d    = 1'b1;
            cnt_d   = 3'd0;
            state_d = StTx;
          end else begin
            state_d = StWaitStop;
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      hold_d = 4'(SDA_HOLD_CYCLES);
      pend_d = 1'b0;
      case (state_q)
        StAddrAck, StPtrHAck, StPtrLAck, StWdataAck: begin
          // First fall starts the ACK bit, second fall ends it
          if (!ack_on_q) begin
            ack_on_d = 1'b1;
            pend_d   = 1'b1;
          end else begin
            ack_on_d = 1'b0;
            cnt_d    = 3'd0;
            case (state_q)
              StAddrAck: begin
                if (rw_q) begin
                  state_d = StTx;
                  pend_d  = ~tx_q[7];
                end else begin
                  state_d = StPtrH;
                end
              end
              StPtrHAck: state_d = StPtrL;
              StPtrLAck: state_d = StWdata;
              default: begin
                state_d = StWdata;
                addr_d  = addr_q + 16'd1;
              end
            endcase
          end
        end
        StTx: pend_d = ~tx_q[3'd7 - cnt_q];
        default: ;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= 3'd0;
      sr_q     <= 8'h00;
      shadow_q <= 8'h00;
      tx_q     <= 8'h00;
      rw_q     <= 1'b0;
      ack_on_q <= 1'b0;
      pend_q   <= 1'b0;
      hold_q   <= 4'd0;
      pull_q   <= 1'b0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      re_dly_q <= 1'b0;
      wdata_q  <= 8'h00;
      addr_q   <= 16'h0000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      shadow_q <= shadow_d;
      tx_q     <= tx_d;
      rw_q     <= rw_d;
      ack_on_q <= ack_on_d;
      pend_q   <= pend_d;
      hold_q   <= hold_d;
      pull_q   <= pull_d;
      we_q     <= we_d;
      re_q     <= re_d;
      re_dly_q <= re_dly_d;
      wdata_q  <= wdata_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sda_pull_o  = pull_q;
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
  assign reg_we_o    = we_q;
  assign reg_re_o    = re_q;
  assign busy_o      = busy_q;
  assign xfer_done_o = done_q;

endmodule

// File: tb/tb_i2c_tof_target_responder.sv
`timescale 1ns / 1ps
// Bench: bit-banged I2C master, register-file peripheral model, scoreboard monitor.
module tb_i2c_tof_target_responder;

  localparam logic [6:0] SLAVE = 7'h11;
  localparam int H = 100;  // quarter SCL period in ns (SCL = 40 clk)

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        msda = 1'b1;
  logic        sda_pull;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_we, reg_re;
  logic [7:0]  reg_rdata = 8'h00;
  logic        busy, xfer_done;
  wire         sda_bus = msda & ~sda_pull;

  i2c_tof_target_responder #(
    .SLAVE_ADDR     (SLAVE),
    .SDA_HOLD_CYCLES(4)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .scl_i      (scl),
    .sda_i      (sda_bus),
    .sda_pull_o (sda_pull),
    .reg_addr_o (reg_addr),
    .reg_wdata_o(reg_wdata),
    .reg_we_o   (reg_we),
    .reg_re_o   (reg_re),
    .reg_rdata_i(reg_rdata),
    .busy_o     (busy),
    .xfer_done_o(xfer_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] exp_we_addr_q[$];
  logic [7:0]  exp_we_data_q[$];
  logic [15:0] exp_re_q[$];
  logic [15:0] m_ptr = 16'h0000;
  int exp_done = 0;
  int seen_done = 0;
  bit saw_pull = 1'b0;
  logic [7:0] wbuf[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Peripheral: read data presented one clk after the read strobe
  always @(posedge clk) if (reg_re) reg_rdata <= reg_addr[7:0] ^ 8'h5A;

  // Scoreboard monitor: pops expected strobes whenever the DUT issues one
  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_we || reg_re) check("we_re_exclusive", {31'd0, reg_we & reg_re}, 32'd0);
      if (reg_we) begin
        check("we_expected", {31'd0, exp_we_addr_q.size() > 0}, 32'd1);
        if (exp_we_addr_q.size() > 0) begin
          check("we_addr", {16'd0, reg_addr}, {16'd0, exp_we_addr_q.pop_front()});
          check("we_data", {24'd0, reg_wdata}, {24'd0, exp_we_data_q.pop_front()});
        end
      end
      if (reg_re) begin
        check("re_expected", {31'd0, exp_re_q.size() > 0}, 32'd1);
        if (exp_re_q.size() > 0) check("re_addr", {16'd0, reg_addr}, {16'd0, exp_re_q.pop_front()});
      end
      if (xfer_done) seen_done++;
      if (sda_pull) saw_pull = 1'b1;
    end
  end

  task automatic i2c_start();
    msda = 1'b1; #H; scl = 1'b1; #H; msda = 1'b0; #H; scl = 1'b0;
  endtask

  task automatic i2c_stop();
    #H; msda = 1'b0; #H; scl = 1'b1; #H; msda = 1'b1; #H;
  endtask

  task automatic bit_w(input logic b);
    #H; msda = b; #H; scl = 1'b1; #H; #H; scl = 1'b0;
  endtask

  task automatic bit_r(output logic b);
    #H; msda = 1'b1; #H; scl = 1'b1; #H; b = sda_bus; #H; scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output bit ack);
    logic x;
    for (int i = 7; i >= 0; i--) bit_w(d[i]);
    bit_r(x);
    ack = ~x;
  endtask

  task automatic read_byte(output logic [7:0] d, input bit mack);
    logic x;
    for (int i = 7; i >= 0; i--) begin
      bit_r(x);
      d[i] = x;
    end
    bit_w(mack ? 1'b0 : 1'b1);
  endtask

  task automatic post_stop_checks(input string tag);
    check({tag, "_ptr"}, {16'd0, reg_addr}, {16'd0, m_ptr});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done_cnt"}, seen_done, exp_done);
  endtask

  // Write transaction: address byte, nptr pointer bytes, nd data bytes from wbuf
  task automatic wr_txn(input logic [6:0] a, input int nptr, input logic [15:0] p,
                        input int nd, input bit do_stop);
    bit ack, match;
    match = (a == SLAVE);
    saw_pull = 1'b0;
    i2c_start();
    write_byte({a, 1'b0}, ack);
    check("addr_ack", {31'd0, ack}, {31'd0, match});
    check("busy_after_addr", {31'd0, busy}, {31'd0, match});
    write_byte(p[15:8], ack);
    check("ptrh_ack", {31'd0, ack}, {31'd0, match});
    if (nptr == 2) begin
      write_byte(p[7:0], ack);
      check("ptrl_ack", {31'd0, ack}, {31'd0, match});
      if (match) m_ptr = p;
    end
    for (int i = 0; i < nd; i++) begin
      if (match) begin
        exp_we_addr_q.push_back(m_ptr);
        exp_we_data_q.push_back(wbuf[i]);
      end
      write_byte(wbuf[i], ack);
      check("wdata_ack", {31'd0, ack}, {31'd0, match});
      if (match) m_ptr = m_ptr + 16'd1;
    end
    if (!match) check("nomatch_no_pull", {31'd0, saw_pull}, 32'd0);
    if (do_stop) begin
      i2c_stop();
      if (match) exp_done++;
      post_stop_checks("wr");
    end
  endtask

  // Read transaction of n bytes from the current pointer; last byte NACKed
  task automatic rd_txn(input int n);
    bit ack;
    logic [7:0] b;
    logic [15:0] base, a;
    base = m_ptr;
    for (int i = 0; i < n; i++) exp_re_q.push_back(base + 16'(i));
    i2c_start();
    write_byte({SLAVE, 1'b1}, ack);
    check("rd_addr_ack", {31'd0, ack}, 32'd1);
    for (int i = 0; i < n; i++) begin
      read_byte(b, i < n - 1);
      a = base + 16'(i);
      check("rd_byte", {24'd0, b}, {24'd0, a[7:0] ^ 8'h5A});
    end
    m_ptr = base + 16'(n - 1);
    i2c_stop();
    exp_done++;
    post_stop_checks("rd");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got;
    bit ack;
    logic [7:0] rb;
    logic [6:0] wa;
    #47;
    check("rst_sda_pull", {31'd0, sda_pull}, 32'd0);
    check("rst_reg_addr", {16'd0, reg_addr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_strobes", {30'd0, reg_we, reg_re}, 32'd0);
    check("rst_done", {31'd0, xfer_done}, 32'd0);
    rst_n = 1'b1;
    #200;

    // Write with auto-increment
    wbuf[0] = 8'hAB; wbuf[1] = 8'hCD;
    wr_txn(SLAVE, 2, 16'h010A, 2, 1'b1);
    check("wr_final_ptr", {16'd0, reg_addr}, 32'h0000_010C);

    // Pointer set then repeated-start read of two bytes
    wr_txn(SLAVE, 2, 16'h010A, 0, 1'b0);
    rd_txn(2);
    check("rd_final_ptr", {16'd0, reg_addr}, 32'h0000_010B);

    // Wrong address
    wr_txn(7'h12, 2, 16'h0000, 0, 1'b1);

    // Pointer wrap
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    wr_txn(SLAVE, 2, 16'hFFFF, 2, 1'b1);
    check("wrap_final_ptr", {16'd0, reg_addr}, 32'h0000_0001);

    // Partial pointer is discarded
    wr_txn(SLAVE, 2, 16'h1234, 0, 1'b1);
    wr_txn(SLAVE, 1, 16'h5600, 0, 1'b1);
    check("partial_ptr_kept", {16'd0, reg_addr}, 32'h0000_1234);

    // Randomized mix
    for (int t = 0; t < 6; t++) begin
      int kind, len;
      kind = $urandom_range(0, 3);
      len = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
      case (kind)
        0: wr_txn(SLAVE, 2, 16'($urandom), len, 1'b1);
        1: rd_txn(len);
        2: begin
          wr_txn(SLAVE, 2, 16'($urandom), 0, 1'b0);
          rd_txn(len);
        end
        default: begin
          wa = 7'($urandom);
          if (wa == SLAVE) wa = wa ^ 7'h01;
          wr_txn(wa, 2, 16'($urandom), len, 1'b1);
        end
      endcase
    end

    // Reset while the target drives SDA low during a read byte (0x33^0x5A = 0x69)
    wr_txn(SLAVE, 2, 16'h0033, 0, 1'b0);
    exp_re_q.push_back(m_ptr);
    i2c_start();
    write_byte({SLAVE, 1'b1}, ack);
    check("rst_rd_addr_ack", {31'd0, ack}, 32'd1);
    fork
      read_byte(rb, 1'b0);
      begin
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
          @(negedge clk);
          got = sda_pull;
        end
        check("rst_pull_seen", {31'd0, got}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pull", {31'd0, sda_pull}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_addr", {16'd0, reg_addr}, 32'd0);
        #30;
        rst_n = 1'b1;
      end
    join
    i2c_stop();
    m_ptr = 16'h0000;
    post_stop_checks("after_rst");

    wbuf[0] = 8'h3C; wbuf[1] = 8'hC3;
    wr_txn(SLAVE, 2, 16'h0200, 2, 1'b1);

    #500;
    check("we_queue_empty", exp_we_addr_q.size(), 32'd0);
    check("re_queue_empty", exp_re_q.size(), 32'd0);
    check("final_done_cnt", seen_done, exp_done);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
